// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/issue controller for the 8-bit CPU.
// Owns the program counter, registers the instruction word returned by the
// combinational instruction memory, and issues it to the execute datapath
// over a valid/ready handshake. Unconditional jumps are resolved here;
// conditional jumps and ATC wait for a branch result from the datapath.
// Optional feature: define BREAKPOINT_EN to enable the run-mode breakpoint.
module pc_sequencer #(
  parameter logic [7:0] RESET_PC  = 8'd0,
  parameter int         NOP_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic        step,
  input  logic        restart,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  output logic [7:0]  pc,
  output logic        halted,
  input  logic [7:0]  bp_addr,
  input  logic        bp_enable,
  output logic        bp_hit
);

  // Instruction field encodings, mirroring the shared CPU definitions.
  localparam logic [2:0] OP_JMP   = 3'd5;
  localparam logic [2:0] OP_ATC   = 3'd6;
  localparam logic [2:0] COND_UNC = 3'd0;

  localparam logic [15:0] NOP_LIMIT_W = 16'(NOP_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_RESOLVE = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        instr_valid_reg, instr_valid_next;
  logic [15:0] nop_count_reg, nop_count_next;
  logic        step_mode_reg, step_mode_next;
  logic        bp_hit_reg, bp_hit_next;
  logic        bp_stop_reg, bp_stop_next;

  logic [7:0]  pc_inc;
  logic [15:0] nop_inc;
  logic [2:0]  fetch_op, fetch_cond, held_op, held_cond;
  logic [7:0]  fetch_target, held_target;
  logic        bp_trip;
  state_t      done_state;

  assign pc_inc       = pc_reg + 8'd1;
  // Saturate so a very long NOP run cannot wrap the counter back below the limit.
  assign nop_inc      = (nop_count_reg == 16'hFFFF) ? nop_count_reg : nop_count_reg + 16'd1;
  assign fetch_op     = imem_data[31:29];
  assign fetch_cond   = imem_data[28:26];
  assign fetch_target = imem_data[7:0];
  assign held_op      = instr_reg[31:29];
  assign held_cond    = instr_reg[28:26];
  assign held_target  = instr_reg[7:0];

  // Where to go once the current word is finished: single-step always parks in IDLE.
  assign done_state = (run && !step_mode_reg) ? S_FETCH : S_IDLE;

`ifdef BREAKPOINT_EN
  // Breakpoint only stops free-running fetches; a step fetch goes through.
  assign bp_trip = !step_mode_reg && bp_enable && (pc_reg == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_addr, bp_enable};
  assign bp_trip   = 1'b0;
`endif

  // Next-state and datapath-register update logic.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    instr_next       = instr_reg;
    instr_valid_next = instr_valid_reg;
    nop_count_next   = nop_count_reg;
    step_mode_next   = step_mode_reg;
    bp_hit_next      = 1'b0;
    bp_stop_next     = bp_stop_reg;

    // Restart is honoured everywhere except while an instruction is in flight.
    if (restart && (state_reg != S_ISSUE) && (state_reg != S_RESOLVE)) begin
      state_next     = S_IDLE;
      pc_next        = RESET_PC;
      nop_count_next = 16'd0;
      step_mode_next = 1'b0;
      bp_stop_next   = 1'b0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          // After a breakpoint, run is ignored until a step moves past it.
          if (run && !bp_stop_reg) begin
            state_next     = S_FETCH;
            step_mode_next = 1'b0;
          end else if (step) begin
            state_next     = S_FETCH;
            step_mode_next = 1'b1;
            bp_stop_next   = 1'b0;
          end
        end

        S_FETCH: begin
          if (bp_trip) begin
            state_next   = S_IDLE;
            bp_hit_next  = 1'b1;
            bp_stop_next = 1'b1;
          end else begin
            instr_next = imem_data;
            if (imem_data == 32'd0) begin
              pc_next        = pc_inc;
              nop_count_next = nop_inc;
              step_mode_next = 1'b0;
              if ((NOP_LIMIT != 0) && (nop_inc >= NOP_LIMIT_W)) begin
                state_next = S_HALTED;
              end else begin
                state_next = done_state;
              end
            end else if ((fetch_op == OP_JMP) && (fetch_cond == COND_UNC)) begin
              pc_next        = fetch_target;
              nop_count_next = 16'd0;
              step_mode_next = 1'b0;
              state_next     = done_state;
            end else begin
              instr_valid_next = 1'b1;
              state_next       = S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (instr_ready) begin
            instr_valid_next = 1'b0;
            nop_count_next   = 16'd0;
            if ((held_op == OP_ATC) || ((held_op == OP_JMP) && (held_cond != COND_UNC))) begin
              state_next = S_RESOLVE;
            end else begin
              pc_next        = pc_inc;
              step_mode_next = 1'b0;
              state_next     = done_state;
            end
          end
        end

        S_RESOLVE: begin
          if (resolve_valid) begin
            pc_next        = resolve_taken ? held_target : pc_inc;
            step_mode_next = 1'b0;
            state_next     = done_state;
          end
        end

        S_HALTED: begin
          state_next = S_HALTED;
        end

        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      pc_reg          <= RESET_PC;
      instr_reg       <= 32'd0;
      instr_valid_reg <= 1'b0;
      nop_count_reg   <= 16'd0;
      step_mode_reg   <= 1'b0;
      bp_hit_reg      <= 1'b0;
      bp_stop_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      instr_reg       <= instr_next;
      instr_valid_reg <= instr_valid_next;
      nop_count_reg   <= nop_count_next;
      step_mode_reg   <= step_mode_next;
      bp_hit_reg      <= bp_hit_next;
      bp_stop_reg     <= bp_stop_next;
    end
  end

  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign halted      = (state_reg == S_HALTED);
  assign bp_hit      = bp_hit_reg;

endmodule
